frame_accumulator: RTL and testbench
====================================

FRAME_ACCUMULATOR -- requirements
Module: frame_accumulator

Interface
REQ-001 Parameter: FRAME_LEN, default 4, results per frame; legal values 2..4.
REQ-002 Parameter: DEPTH, fixed at 2, output FIFO entries.
REQ-003 Port: clock  in  1  single clock; all state updates on its rising edge.
REQ-004 Port: reset  in  1  synchronous, active-high reset.
REQ-005 Port: in_data  in  8  one A*B+C result from the upstream multiply-add stage.
REQ-006 Port: in_valid  in  1  in_data holds a result this cycle.
REQ-007 Port: in_ready  out  1  block accepts in_data this cycle.
REQ-008 Port: sum_data  out  10  unsigned sum of one frame.
REQ-009 Port: sum_tag  out  4  frame sequence number of sum_data.
REQ-010 Port: sum_valid  out  1  sum_data and sum_tag are valid.
REQ-011 Port: sum_ready  in  1  downstream takes the sum this cycle.

Function
REQ-012 Input beat accepted iff in_valid && in_ready on a rising edge; no other cycle changes the accumulator.
REQ-013 Beat index idx counts 0..FRAME_LEN-1 over accepted beats; wraps to 0 after the last beat.
REQ-014 On an accepted beat with idx==0, acc <= in_data zero-extended to 10 bits; otherwise acc <= acc + in_data.
REQ-015 On an accepted beat with idx==FRAME_LEN-1: push {acc+in_data, frame_tag} into the FIFO, frame_tag <= frame_tag+1 (mod 16), idx <= 0.
REQ-016 Sum is unsigned, 10 bits, and never overflows (4*255=1020).
REQ-017 Gaps (in_valid low) in the middle of a frame leave idx and acc unchanged.
REQ-018 FIFO occupancy states: EMPTY(0), ONE(1), FULL(2); transitions: push only +1, pop only -1, push and pop together hold.
REQ-019 in_ready = (occupancy != FULL), combinational from registered occupancy only; no dependence on sum_ready.
REQ-020 sum_valid = (occupancy != EMPTY); sum_data/sum_tag = head entry; both stable while sum_valid && !sum_ready.
REQ-021 Pop iff sum_valid && sum_ready.
REQ-022 Latency: last beat accepted at edge N with FIFO EMPTY -> sum_valid high after edge N, visible in cycle N+1.
REQ-023 FIFO in ONE, push and pop at the same edge: new entry becomes head next cycle, occupancy stays ONE, no sum lost or duplicated.
REQ-024 FIFO FULL: in_ready low, no beat accepted (including non-last beats) until a pop.
REQ-025 Sums leave in frame order; tag increments by exactly 1 between consecutive outputs.
REQ-026 When sum_valid is low, sum_data and sum_tag are 0.

Reset
REQ-027 Reset at an edge: idx=0, acc=0, frame_tag=0, FIFO EMPTY, so sum_valid=0, sum_data=0, sum_tag=0, and in_ready=1 in the following cycle.
REQ-028 Reset mid-frame discards partial sums; the reset wins over a beat or pop in the same cycle; the next accepted beat starts a fresh frame with idx 0.

Verification
REQ-029 Basic: beats 10,20,30,40 with sum_ready=1 -> one cycle after the 4th beat, sum_valid=1, sum_data=100, sum_tag=0, held for one cycle.
REQ-030 Max: 4 beats of 255 -> sum_data=1020; next frame 1,1,1,1 -> sum_data=4, sum_tag=1.
REQ-031 Backpressure: sum_ready=0, three frames of 1,2,3,4 offered back-to-back -> in_ready low after the 2nd frame's last beat; raise sum_ready -> outputs 10(tag0), 10(tag1), 10(tag2) in order.
REQ-032 Gaps: beats 5,_,6,_,_,7,8 (_ = in_valid low) -> single sum 26; idx unchanged during gaps.
REQ-033 Reset mid-frame: beats 100,100, assert reset for 1 cycle, then 1,2,3,4 -> sum_data=10, sum_tag=0.
REQ-034 Simultaneous push/pop: occupancy ONE, sum_ready=1 while the next frame's last beat lands -> continuous sum_valid, no dropped or repeated tag.

Source files
------------

// File: rtl/frame_accumulator.sv
// Frame accumulator: sums FRAME_LEN multiply-add results into one tagged
// frame total and queues the totals in a small output FIFO.

// Generic synchronous FIFO with a registered occupancy count.
// Latency: a push is visible at the head in the cycle after the write edge.
// Backpressure: push_rdy drops when full; pop_dat reads as zero when empty.
module fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    output logic             push_rdy,
    output logic             pop_vld,
    output logic [WIDTH-1:0] pop_dat,
    input  logic             pop_rdy
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign push_rdy = (count != CW'(DEPTH));
    assign pop_vld  = (count != '0);
    assign pop_dat  = pop_vld ? mem[rd_ptr] : '0;
    assign do_push  = push_vld && push_rdy;
    assign do_pop   = pop_vld && pop_rdy;

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            // Simultaneous push and pop leave the occupancy unchanged.
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CW'(1);
            end
        end
    end
endmodule

// Accumulates FRAME_LEN input beats into a 10-bit sum tagged with a 4-bit frame number.
// Latency: sum_valid rises in the cycle after the frame's last beat is accepted.
// Backpressure: in_ready depends only on FIFO occupancy; a full FIFO stalls every beat.
module frame_accumulator #(
    parameter int FRAME_LEN = 4,
    parameter int DEPTH     = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [9:0] sum_data,
    output logic [3:0] sum_tag,
    output logic       sum_valid,
    input  logic       sum_ready
);
    typedef struct packed {
        logic [9:0] sum;
        logic [3:0] tag;
    } sum_t;

    logic [1:0] idx;
    logic [9:0] acc;
    logic [3:0] frame_tag;
    logic       beat_vld;
    logic       last_beat;
    logic [9:0] next_sum;
    sum_t       push_dat;
    sum_t       head_dat;
    logic       push_rdy;

    assign beat_vld  = in_valid && in_ready;
    assign last_beat = (idx == 2'(FRAME_LEN - 1));
    // The first beat of a frame overwrites whatever the accumulator held.
    assign next_sum  = ((idx == 2'd0) ? 10'd0 : acc) + {2'b00, in_data};
    assign push_dat  = '{sum: next_sum, tag: frame_tag};
    assign in_ready  = push_rdy;

    always_ff @(posedge clock) begin
        if (reset) begin
            idx       <= 2'd0;
            acc       <= 10'd0;
            frame_tag <= 4'd0;
        end else if (beat_vld) begin
            acc <= next_sum;
            if (last_beat) begin
                idx       <= 2'd0;
                frame_tag <= frame_tag + 4'd1;
            end else begin
                idx <= idx + 2'd1;
            end
        end
    end

    fifo #(
        .WIDTH ($bits(sum_t)),
        .DEPTH (DEPTH)
    ) u_sum_fifo (
        .clock    (clock),
        .reset    (reset),
        .push_vld (beat_vld && last_beat),
        .push_dat (push_dat),
        .push_rdy (push_rdy),
        .pop_vld  (sum_valid),
        .pop_dat  (head_dat),
        .pop_rdy  (sum_ready)
    );

    assign sum_data = head_dat.sum;
    assign sum_tag  = head_dat.tag;
endmodule

// File: tb/tb_frame_accumulator.sv
// Randomised and directed bench for frame_accumulator with a frame-level reference model.
module tb_frame_accumulator;
    localparam int FRAME_LEN = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] in_data = 8'd0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [9:0] sum_data;
    logic [3:0] sum_tag;
    logic       sum_valid;
    logic       sum_ready = 1'b1;

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;
    bit rand_ready = 1'b0;

    logic [13:0] exp_q [$];
    int          frame_beats [$];
    int          model_tag = 0;

    frame_accumulator #(.FRAME_LEN(FRAME_LEN), .DEPTH(2)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum_data  (sum_data),
        .sum_tag   (sum_tag),
        .sum_valid (sum_valid),
        .sum_ready (sum_ready)
    );

    always #5 clock = ~clock;

    // Reference model: collect accepted beats, emit the frame total when complete.
    always @(posedge clock) begin
        if (reset) begin
            exp_q.delete();
            frame_beats.delete();
            model_tag = 0;
        end else if (in_valid && in_ready) begin
            frame_beats.push_back(int'(in_data));
            if (frame_beats.size() == FRAME_LEN) begin
                int s;
                s = 0;
                foreach (frame_beats[i]) s += frame_beats[i];
                exp_q.push_back({10'(s), 4'(model_tag)});
                model_tag = (model_tag + 1) % 16;
                frame_beats.delete();
            end
        end
    end

    // Monitor: every handshaken output is compared against the oldest expected sum.
    always @(posedge clock) begin
        if (started && !reset && sum_valid && sum_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_sum got data=%0d tag=%0d, expected no output", sum_data, sum_tag);
            end else begin
                logic [13:0] e;
                e = exp_q.pop_front();
                if ({sum_data, sum_tag} !== e) begin
                    errors++;
                    $display("FAIL sum_out got data=%0d tag=%0d, expected data=%0d tag=%0d",
                             sum_data, sum_tag, e[13:4], e[3:0]);
                end
            end
        end
    end

    // Cycle checks of flow-control outputs against model occupancy.
    always @(negedge clock) begin
        if (started) begin
            checks++;
            if (in_ready !== (exp_q.size() < 2)) begin
                errors++;
                $display("FAIL in_ready got %b, expected %b (occupancy %0d)", in_ready, exp_q.size() < 2, exp_q.size());
            end
            checks++;
            if (sum_valid !== (exp_q.size() != 0)) begin
                errors++;
                $display("FAIL sum_valid got %b, expected %b (occupancy %0d)", sum_valid, exp_q.size() != 0, exp_q.size());
            end
            if (sum_valid === 1'b0) begin
                checks++;
                if (sum_data !== 10'd0 || sum_tag !== 4'd0) begin
                    errors++;
                    $display("FAIL idle_zero got data=%0d tag=%0d, expected 0 0", sum_data, sum_tag);
                end
            end
        end
        if (rand_ready) sum_ready = ($urandom_range(0, 2) != 0);
    end

    task automatic send_beat(input logic [7:0] d);
        bit done;
        in_valid = 1'b1;
        in_data  = d;
        done = 1'b0;
        for (int n = 0; n < 200 && !done; n++) begin
            bit rdy;
            rdy = in_ready;
            @(posedge clock);
            @(negedge clock);
            done = rdy;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL beat_timeout beat %0d never accepted, expected acceptance within 200 cycles", d);
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clock);
    endtask

    task automatic send_frame(input int a, input int b, input int c, input int d);
        send_beat(8'(a));
        send_beat(8'(b));
        send_beat(8'(c));
        send_beat(8'(d));
    endtask

    initial begin
        repeat (2) @(negedge clock);
        reset = 1'b0;
        started = 1'b1;
        @(negedge clock);

        // Basic and maximum-value frames.
        send_frame(10, 20, 30, 40);
        idle(2);
        send_frame(255, 255, 255, 255);
        send_frame(1, 1, 1, 1);
        idle(2);

        // Backpressure: three frames against a stalled output.
        sum_ready = 1'b0;
        fork
            begin
                send_frame(1, 2, 3, 4);
                send_frame(1, 2, 3, 4);
                send_frame(1, 2, 3, 4);
            end
            begin
                repeat (20) @(negedge clock);
                sum_ready = 1'b1;
            end
        join
        idle(4);

        // Gaps inside a frame.
        send_beat(8'd5); idle(1);
        send_beat(8'd6); idle(2);
        send_beat(8'd7);
        send_beat(8'd8);
        idle(2);

        // Reset mid-frame, then a fresh frame.
        send_beat(8'd100);
        send_beat(8'd100);
        in_valid = 1'b1;
        in_data  = 8'd77;
        reset    = 1'b1;
        @(negedge clock);
        reset    = 1'b0;
        in_valid = 1'b0;
        send_frame(1, 2, 3, 4);
        idle(2);

        // Push and pop at the same edge with one entry queued.
        sum_ready = 1'b0;
        send_frame(9, 9, 9, 9);
        send_beat(8'd3); send_beat(8'd3); send_beat(8'd3);
        sum_ready = 1'b1;
        send_beat(8'd3);
        idle(3);

        // Random traffic with random output stalls.
        rand_ready = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            else send_beat(8'($urandom_range(0, 255)));
        end
        idle(1);
        rand_ready = 1'b0;
        sum_ready  = 1'b1;
        for (int n = 0; n < 50 && exp_q.size() != 0; n++) @(negedge clock);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d sums outstanding, expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
